// File: rtl/fix2flt_seq.sv
// Signed fixed-point to {sign, exp, man} float converter, normalising one bit per cycle.
// Latency: done pulses 4+lz cycles after start is accepted (lz = leading zeros of |fix_in|).
// Backpressure: none; start is ignored while busy, and a start in the done cycle is accepted.
module fix2flt_seq #(
    parameter int FIX_W    = 16,
    parameter int FRAC_W   = 8,
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int RND_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [FIX_W-1:0]       fix_in,
    output logic                   done,
    output logic                   busy,
    output logic [EXP_W+MAN_W:0]   flt_out,
    output logic                   ovf,
    output logic                   uf
);

    localparam int LZ_W  = $clog2(FIX_W) + 1;
    localparam int EXT_W = FIX_W + MAN_W;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int E_MAX = 2**EXP_W - 1;
    // Biased exponent of a magnitude whose MSB is already set (lz = 0).
    localparam int E_TOP = FIX_W - 1 - FRAC_W + BIAS;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NORM, S_PACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FIX_W-1:0]  fix_q;
    logic [FIX_W-1:0]  mag;
    logic              sign;
    logic [LZ_W-1:0]   lz;

    // Pack-stage combinational results.
    logic [EXT_W-1:0]      ext;
    logic [MAN_W-1:0]      man_t;
    logic                  guard;
    logic                  sticky;
    logic                  inc;
    logic [MAN_W:0]        man_r;
    int                    e_b;
    logic [EXP_W+MAN_W:0]  flt_nxt;
    logic                  ovf_nxt;
    logic                  uf_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: normalisation stops once the MSB is set or the value is zero.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_NORM;
            S_NORM: if (mag[FIX_W-1] || (mag == '0)) state_nxt = S_PACK;
            S_PACK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, sign/magnitude split and one-bit-per-cycle left shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            fix_q <= '0;
            mag   <= '0;
            sign  <= 1'b0;
            lz    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) fix_q <= fix_in;
                S_LOAD: begin
                    sign <= fix_q[FIX_W-1];
                    // Most negative input negates to 2^(FIX_W-1), which is the right magnitude.
                    mag  <= fix_q[FIX_W-1] ? (~fix_q + 1'b1) : fix_q;
                    lz   <= '0;
                end
                S_NORM: if (!mag[FIX_W-1] && (mag != '0)) begin
                    mag <= {mag[FIX_W-2:0], 1'b0};
                    lz  <= lz + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Mantissa extraction, optional round-to-nearest-even, exponent range handling.
    always_comb begin
        // Drop the hidden bit and zero-pad so narrow inputs still fill the mantissa.
        ext     = {mag[FIX_W-2:0], {(MAN_W+1){1'b0}}};
        man_t   = ext[EXT_W-1 -: MAN_W];
        guard   = ext[EXT_W-1-MAN_W];
        sticky  = |ext[EXT_W-2-MAN_W:0];
        inc     = (RND_MODE == 1) && guard && (sticky || man_t[0]);
        man_r   = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
        // Mantissa carry-out leaves man_r[MAN_W-1:0] at zero and bumps the exponent.
        e_b     = E_TOP - int'(lz) + int'(man_r[MAN_W]);
        flt_nxt = '0;
        ovf_nxt = 1'b0;
        uf_nxt  = 1'b0;
        if (mag == '0) begin
            flt_nxt = '0;
        end else if (e_b >= E_MAX) begin
            flt_nxt = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_nxt = 1'b1;
        end else if (e_b <= 0) begin
            flt_nxt = {sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
            uf_nxt  = 1'b1;
        end else begin
            flt_nxt = {sign, EXP_W'(e_b), man_r[MAN_W-1:0]};
        end
    end

    // Result registers: updated only in PACK and held until the next result.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            flt_out <= '0;
            ovf     <= 1'b0;
            uf      <= 1'b0;
        end else begin
            done <= (state == S_PACK);
            if (state == S_PACK) begin
                flt_out <= flt_nxt;
                ovf     <= ovf_nxt;
                uf      <= uf_nxt;
            end
        end
    end

    // Busy covers the whole conversion including the cycle that presents done.
    assign busy = (state != S_IDLE) || done;

endmodule

// File: tb/tb_fix2flt_seq.sv
// Bench for fix2flt_seq: default, round-to-nearest-even and narrow-exponent instances.
// Vectors are driven to all three instances at once; their timing is parameter independent.
// Start/done handshake corner cases and mid-conversion reset are hand-sequenced.
module tb_fix2flt_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] fix_in;

    logic        done_def, busy_def, ovf_def, uf_def;
    logic [15:0] flt_def;
    logic        done_rnd, busy_rnd, ovf_rnd, uf_rnd;
    logic [15:0] flt_rnd;
    logic        done_e3, busy_e3, ovf_e3, uf_e3;
    logic [13:0] flt_e3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fix2flt_seq u_def (
        .clk(clk), .reset(reset), .start(start), .fix_in(fix_in),
        .done(done_def), .busy(busy_def), .flt_out(flt_def), .ovf(ovf_def), .uf(uf_def)
    );

    fix2flt_seq #(.RND_MODE(1)) u_rnd (
        .clk(clk), .reset(reset), .start(start), .fix_in(fix_in),
        .done(done_rnd), .busy(busy_rnd), .flt_out(flt_rnd), .ovf(ovf_rnd), .uf(uf_rnd)
    );

    fix2flt_seq #(.EXP_W(3)) u_e3 (
        .clk(clk), .reset(reset), .start(start), .fix_in(fix_in),
        .done(done_e3), .busy(busy_e3), .flt_out(flt_e3), .ovf(ovf_e3), .uf(uf_e3)
    );

    typedef struct {
        logic [15:0] fix;
        int          lat;
        logic [15:0] f_def;
        logic        o_def;
        logic        u_def;
        logic [15:0] f_rnd;
        logic [13:0] f_e3;
        logic        o_e3;
        logic        u_e3;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents start for one cycle; returns at the falling edge of cycle T+1.
    task automatic launch(input logic [15:0] f);
        @(negedge clk);
        fix_in = f;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts cycles from cycle index 'first' until done, bounded; busy must stay high throughout.
    task automatic wait_done(input int first, output int lat, output bit busy_ok);
        lat     = first;
        busy_ok = 1'b1;
        while (!done_def && lat < 64) begin
            if (!busy_def) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy_def) busy_ok = 1'b0;
    endtask

    initial begin
        int lat;
        bit bok;

        vt[0]  = '{16'h0001, 19, 16'h1C00, 1'b0, 1'b0, 16'h1C00, 14'h0000, 1'b0, 1'b1};
        vt[1]  = '{16'h000C, 16, 16'h2A00, 1'b0, 1'b0, 16'h2A00, 14'h0000, 1'b0, 1'b1};
        vt[2]  = '{16'h8000,  4, 16'hD800, 1'b0, 1'b0, 16'hD800, 14'h3C00, 1'b1, 1'b0};
        vt[3]  = '{16'hFFFF, 19, 16'h9C00, 1'b0, 1'b0, 16'h9C00, 14'h2000, 1'b0, 1'b1};
        vt[4]  = '{16'h0000,  4, 16'h0000, 1'b0, 1'b0, 16'h0000, 14'h0000, 1'b0, 1'b0};
        vt[5]  = '{16'h7FFF,  5, 16'h57FF, 1'b0, 1'b0, 16'h5800, 14'h1C00, 1'b1, 1'b0};
        vt[6]  = '{16'h8001,  5, 16'hD7FF, 1'b0, 1'b0, 16'hD800, 14'h3C00, 1'b1, 1'b0};
        vt[7]  = '{16'h1000,  7, 16'h4C00, 1'b0, 1'b0, 16'h4C00, 14'h1C00, 1'b1, 1'b0};
        vt[8]  = '{16'hF000,  7, 16'hCC00, 1'b0, 1'b0, 16'hCC00, 14'h3C00, 1'b1, 1'b0};
        vt[9]  = '{16'h0020, 14, 16'h3000, 1'b0, 1'b0, 16'h3000, 14'h0000, 1'b0, 1'b1};
        vt[10] = '{16'h0040, 13, 16'h3400, 1'b0, 1'b0, 16'h3400, 14'h0400, 1'b0, 1'b0};
        vt[11] = '{16'h4008,  5, 16'h5400, 1'b0, 1'b0, 16'h5400, 14'h1C00, 1'b1, 1'b0};
        vt[12] = '{16'h4018,  5, 16'h5401, 1'b0, 1'b0, 16'h5402, 14'h1C00, 1'b1, 1'b0};
        vt[13] = '{16'h4009,  5, 16'h5400, 1'b0, 1'b0, 16'h5401, 14'h1C00, 1'b1, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        fix_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", {31'b0, done_def}, 32'd0);
        chk("reset_busy", {31'b0, busy_def}, 32'd0);
        chk("reset_flt",  {16'b0, flt_def},  32'd0);
        chk("reset_ovf_uf", {30'b0, ovf_def, uf_def}, 32'd0);
        reset = 1'b0;

        // Table-driven conversions.
        for (int i = 0; i < 14; i++) begin
            launch(vt[i].fix);
            wait_done(1, lat, bok);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_busy", i), {31'b0, bok}, 32'd1);
            chk($sformatf("v%0d_done_all", i), {30'b0, done_rnd, done_e3}, 32'd3);
            chk($sformatf("v%0d_flt_def", i), {16'b0, flt_def}, {16'b0, vt[i].f_def});
            chk($sformatf("v%0d_flags_def", i), {30'b0, ovf_def, uf_def}, {30'b0, vt[i].o_def, vt[i].u_def});
            chk($sformatf("v%0d_flt_rnd", i), {16'b0, flt_rnd}, {16'b0, vt[i].f_rnd});
            chk($sformatf("v%0d_flt_e3", i), {18'b0, flt_e3}, {18'b0, vt[i].f_e3});
            chk($sformatf("v%0d_flags_e3", i), {30'b0, ovf_e3, uf_e3}, {30'b0, vt[i].o_e3, vt[i].u_e3});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {30'b0, done_def, busy_def}, 32'd0);
            chk($sformatf("v%0d_flt_held", i), {16'b0, flt_def}, {16'b0, vt[i].f_def});
        end

        // start while busy is ignored.
        launch(16'h0001);
        repeat (3) @(negedge clk);
        fix_in = 16'h7FFF;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(5, lat, bok);
        chk("busy_start_latency", lat, 19);
        chk("busy_start_flt", {16'b0, flt_def}, 32'h1C00);

        // start in the done cycle is accepted.
        fix_in = 16'h0030;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(1, lat, bok);
        chk("done_start_latency", lat, 14);
        chk("done_start_busy", {31'b0, bok}, 32'd1);
        chk("done_start_flt", {16'b0, flt_def}, 32'h3200);

        // Reset in the middle of normalisation.
        launch(16'h0001);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_done_busy", {30'b0, done_def, busy_def}, 32'd0);
        chk("midreset_flt", {16'b0, flt_def}, 32'd0);
        chk("midreset_flags", {30'b0, ovf_def, uf_def}, 32'd0);
        reset = 1'b0;
        launch(16'h0100);
        wait_done(1, lat, bok);
        chk("after_reset_latency", lat, 11);
        chk("after_reset_flt", {16'b0, flt_def}, 32'h3C00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
